fu_result_arbiter: RTL and testbench
====================================

// Module: fu_result_arbiter
// PURPOSE
//  Shares the common data bus (CDB) and the ROB write port between NUM_FU functional units (ALU, mult, load, ...).
//  Each FU output stage raises a CDB request and a ROB request and holds its payload; this block grants at most one FU per bus per cycle.
//  Two independent round-robin arbiters with registered bus outputs. Sits between the FU output stages and the CDB/ROB.
// PARAMETERS
//  NUM_FU     4  number of requesting functional units (2..8)
//  ROB_ID_W   4  ROB tag width
//  DATA_W     8  result / flags / wbs width
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst            in   1                 asynchronous, active-low reset (0 = reset)
//  flush          in   1                 sync pipeline flush: clears grants and bus outputs
//  cdb_req        in   NUM_FU            per-FU CDB request (level, held until granted)
//  cdb_req_id     in   NUM_FU*ROB_ID_W   per-FU CDB tag
//  cdb_req_val    in   NUM_FU*DATA_W     per-FU CDB value
//  cdb_gnt        out  NUM_FU            one-hot CDB grant pulse
//  cdb_valid      out  1                 CDB broadcast valid
//  cdb_id         out  ROB_ID_W          CDB tag
//  cdb_val        out  DATA_W            CDB value
//  rob_req        in   NUM_FU            per-FU ROB write request
//  rob_req_id     in   NUM_FU*ROB_ID_W   per-FU ROB index
//  rob_req_flags  in   NUM_FU*DATA_W     per-FU flags
//  rob_req_wbs    in   NUM_FU*DATA_W     per-FU writeback select
//  rob_req_value  in   NUM_FU*DATA_W     per-FU result
//  rob_gnt        out  NUM_FU            one-hot ROB grant pulse
//  rob_valid      out  1                 ROB write valid
//  rob_id, rob_flags, rob_wbs, rob_value  out  ROB_ID_W/DATA_W x3  registered ROB write payload
// BEHAVIOUR
//  - Reset (rst=0, async): all grants, valids and payload outputs 0; both RR pointers = 0.
//  - Each edge, per bus: eligible = req & ~gnt_q (FU granted last cycle is masked; it drops req the cycle after seeing gnt).
//  - Winner = first eligible index scanning ptr, ptr+1, ... wrapping mod NUM_FU.
//  - Latency 1: req sampled at edge t -> gnt[winner], valid=1 and muxed payload registered, visible cycle t+1, high exactly 1 cycle.
//  - No eligible request -> gnt=0, valid=0, payload outputs hold previous value (don't-care).
//  - Pointer update on grant only: ptr <= (winner+1) mod NUM_FU; wrap from NUM_FU-1 to 0. Unchanged on idle cycle.
//  - Fairness: with all FUs requesting continuously, each is granted once every NUM_FU cycles; max wait NUM_FU-1 grants.
//  - CDB and ROB arbiters are independent: the same FU may win both in one cycle, or different FUs each.
//  - flush=1: next edge forces gnt=0, valid=0 on both buses; pointers kept. Flush beats pending requests.
//  - Reset mid-grant: outputs drop asynchronously; a granted-but-unreleased FU sees no grant and must re-request.
//  - Grants are always one-hot or zero; valid == |gnt.
// STRUCTURE
//  - Shared package (core_pkg): ROB_ID_W, DATA_W, typedef cdb_msg_t {id,val}, typedef rob_msg_t {id,flags,wbs,value}.
//  - One sub-module, rr_arbiter #(N): req, mask -> one-hot gnt, internal pointer, async active-low reset;
//    instantiated twice (CDB, ROB). Payload muxing and output registers live in fu_result_arbiter.
// TESTING
//  1. Reset: rst=0 with all req=1 -> all gnt/valid 0; release rst -> first grant FU0 one cycle later.
//  2. Single requester: cdb_req=4'b0100, id=3, val=8'h2A, dropped after gnt -> one cycle cdb_gnt=0100, valid=1, id=3, val=2A, then idle.
//  3. All 4 request continuously (re-raising after 1 idle cycle) -> CDB grant order 0,1,2,3,0,... and no FU granted on consecutive cycles.
//  4. ptr=3, req=4'b1001 -> FU3 granted, ptr wraps to 0, next grant FU0.
//  5. cdb_req=0001, rob_req=0010 same cycle -> cdb_gnt=0001 and rob_gnt=0010 simultaneously, payloads from correct FUs (ROB value 8'h51, flags 8'h02).
//  6. flush=1 with req=1111 -> next cycle gnt=0, valid=0; flush=0 -> arbitration resumes from retained pointer.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : core_pkg                                               |
// | Description : Shared widths and bus message types for the result     |
// |               writeback path (CDB broadcast and ROB write port).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package core_pkg;

  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 8;

  // One CDB broadcast: ROB tag plus result value
  typedef struct packed {
    logic [ROB_ID_W-1:0] id;
    logic [DATA_W-1:0]   val;
  } cdb_msg_t;

  // One ROB write: entry index plus flags, writeback select and result
  typedef struct packed {
    logic [ROB_ID_W-1:0] id;
    logic [DATA_W-1:0]   flags;
    logic [DATA_W-1:0]   wbs;
    logic [DATA_W-1:0]   value;
  } rob_msg_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter                                             |
// | Description : Round-robin arbiter. Combinational one-hot grant over  |
// |               (req & ~mask), scanning from an internal pointer that  |
// |               moves past the winner whenever a grant is taken.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,    // asynchronous, active-low
  input  logic         en,     // grant is actually taken this cycle
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W:0]   w_idx;
  logic [N-1:0]     w_elig;
  logic             w_found;

  // Scan eligible requests starting at the pointer, wrapping modulo N
  always_comb begin
    w_elig  = req & ~mask;
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(N)) begin
        w_idx = w_idx - (PTR_W+1)'(N);
      end
      if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
    if (w_found) begin
      gnt[w_win] = 1'b1;
    end
    ptr_d = ptr_q;
    if (en && w_found) begin
      ptr_d = (w_win == PTR_W'(N-1)) ? '0 : w_win + 1'b1;
    end
  end

  // Pointer register; reset restarts the scan at index 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fu_result_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fu_result_arbiter                                      |
// | Description : Shares the CDB and the ROB write port between NUM_FU   |
// |               functional units with two independent round-robin      |
// |               arbiters and registered bus outputs (latency 1).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fu_result_arbiter
  import core_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                       clk,
  input  logic                       rst,     // asynchronous, active-low
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          cdb_req,
  input  logic [NUM_FU*ROB_ID_W-1:0] cdb_req_id,
  input  logic [NUM_FU*DATA_W-1:0]   cdb_req_val,
  output logic [NUM_FU-1:0]          cdb_gnt,
  output logic                       cdb_valid,
  output logic [ROB_ID_W-1:0]        cdb_id,
  output logic [DATA_W-1:0]          cdb_val,
  input  logic [NUM_FU-1:0]          rob_req,
  input  logic [NUM_FU*ROB_ID_W-1:0] rob_req_id,
  input  logic [NUM_FU*DATA_W-1:0]   rob_req_flags,
  input  logic [NUM_FU*DATA_W-1:0]   rob_req_wbs,
  input  logic [NUM_FU*DATA_W-1:0]   rob_req_value,
  output logic [NUM_FU-1:0]          rob_gnt,
  output logic                       rob_valid,
  output logic [ROB_ID_W-1:0]        rob_id,
  output logic [DATA_W-1:0]          rob_flags,
  output logic [DATA_W-1:0]          rob_wbs,
  output logic [DATA_W-1:0]          rob_value
);

  logic [NUM_FU-1:0] w_cdb_gnt;
  logic [NUM_FU-1:0] w_rob_gnt;
  cdb_msg_t          w_cdb_mux;
  rob_msg_t          w_rob_mux;

  logic [NUM_FU-1:0] cdb_gnt_q, cdb_gnt_d;
  logic [NUM_FU-1:0] rob_gnt_q, rob_gnt_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic              rob_valid_q, rob_valid_d;
  cdb_msg_t          cdb_msg_q, cdb_msg_d;
  rob_msg_t          rob_msg_q, rob_msg_d;

  // The FU granted last cycle is masked: it has not yet dropped its request.
  // Pointers only advance when the grant is really issued (not on flush).
  rr_arbiter #(.N(NUM_FU)) u_cdb_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (~flush),
    .req  (cdb_req),
    .mask (cdb_gnt_q),
    .gnt  (w_cdb_gnt)
  );

  rr_arbiter #(.N(NUM_FU)) u_rob_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (~flush),
    .req  (rob_req),
    .mask (rob_gnt_q),
    .gnt  (w_rob_gnt)
  );

  // Select the winning FU's payload on each bus (one-hot grant)
  always_comb begin
    w_cdb_mux = '0;
    w_rob_mux = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_cdb_gnt[i]) begin
        w_cdb_mux.id  = cdb_req_id[i*ROB_ID_W +: ROB_ID_W];
        w_cdb_mux.val = cdb_req_val[i*DATA_W +: DATA_W];
      end
      if (w_rob_gnt[i]) begin
        w_rob_mux.id    = rob_req_id[i*ROB_ID_W +: ROB_ID_W];
        w_rob_mux.flags = rob_req_flags[i*DATA_W +: DATA_W];
        w_rob_mux.wbs   = rob_req_wbs[i*DATA_W +: DATA_W];
        w_rob_mux.value = rob_req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next bus state: flush suppresses grants; payload holds when idle
  always_comb begin
    cdb_gnt_d   = flush ? '0 : w_cdb_gnt;
    rob_gnt_d   = flush ? '0 : w_rob_gnt;
    cdb_valid_d = |cdb_gnt_d;
    rob_valid_d = |rob_gnt_d;
    cdb_msg_d   = cdb_valid_d ? w_cdb_mux : cdb_msg_q;
    rob_msg_d   = rob_valid_d ? w_rob_mux : rob_msg_q;
  end

  // Registered bus outputs; reset clears them asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_gnt_q   <= '0;
      rob_gnt_q   <= '0;
      cdb_valid_q <= 1'b0;
      rob_valid_q <= 1'b0;
      cdb_msg_q   <= '0;
      rob_msg_q   <= '0;
    end else begin
      cdb_gnt_q   <= cdb_gnt_d;
      rob_gnt_q   <= rob_gnt_d;
      cdb_valid_q <= cdb_valid_d;
      rob_valid_q <= rob_valid_d;
      cdb_msg_q   <= cdb_msg_d;
      rob_msg_q   <= rob_msg_d;
    end
  end

  assign cdb_gnt   = cdb_gnt_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_id    = cdb_msg_q.id;
  assign cdb_val   = cdb_msg_q.val;
  assign rob_gnt   = rob_gnt_q;
  assign rob_valid = rob_valid_q;
  assign rob_id    = rob_msg_q.id;
  assign rob_flags = rob_msg_q.flags;
  assign rob_wbs   = rob_msg_q.wbs;
  assign rob_value = rob_msg_q.value;

endmodule
`default_nettype wire

// File: tb/tb_fu_result_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fu_result_arbiter                                   |
// | Description : Directed bench for fu_result_arbiter with a reference  |
// |               model compared every cycle plus literal spot checks.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fu_result_arbiter;

  localparam int NF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  cdb_req = '0, rob_req = '0;
  logic [15:0] cdb_req_id, rob_req_id;
  logic [31:0] cdb_req_val, rob_req_flags, rob_req_wbs, rob_req_value;
  logic [3:0]  cdb_gnt, rob_gnt;
  logic        cdb_valid, rob_valid;
  logic [3:0]  cdb_id, rob_id;
  logic [7:0]  cdb_val, rob_flags, rob_wbs, rob_value;

  int vectors = 0;
  int errors  = 0;

  fu_result_arbiter #(.NUM_FU(NF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cdb_req(cdb_req), .cdb_req_id(cdb_req_id), .cdb_req_val(cdb_req_val),
    .cdb_gnt(cdb_gnt), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .rob_req(rob_req), .rob_req_id(rob_req_id), .rob_req_flags(rob_req_flags),
    .rob_req_wbs(rob_req_wbs), .rob_req_value(rob_req_value),
    .rob_gnt(rob_gnt), .rob_valid(rob_valid), .rob_id(rob_id),
    .rob_flags(rob_flags), .rob_wbs(rob_wbs), .rob_value(rob_value)
  );

  always #5 clk = ~clk;

  // Fixed per-FU payloads: FU2 CDB id=3 val=2A; FU1 ROB flags=02 value=51
  initial begin
    for (int i = 0; i < NF; i++) begin
      cdb_req_id[i*4 +: 4]    = 4'(i + 1);
      cdb_req_val[i*8 +: 8]   = 8'(8'h28 + i);
      rob_req_id[i*4 +: 4]    = 4'(8 + i);
      rob_req_flags[i*8 +: 8] = 8'(i + 1);
      rob_req_wbs[i*8 +: 8]   = 8'(8'h10 + i);
      rob_req_value[i*8 +: 8] = 8'(8'h50 + i);
    end
  end

  // ---------------- reference model ----------------
  int         m_cptr = 0, m_rptr = 0;
  logic [3:0] m_cgnt = '0, m_rgnt = '0;
  logic [3:0] m_cid = '0, m_rid = '0;
  logic [7:0] m_cval = '0, m_rflags = '0, m_rwbs = '0, m_rval = '0;

  function automatic int pick(input logic [3:0] elig, input int start);
    for (int k = 0; k < NF; k++) begin
      if (elig[(start + k) % NF]) return (start + k) % NF;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int w;
    if (!rst) begin
      m_cptr = 0; m_rptr = 0; m_cgnt = '0; m_rgnt = '0;
      m_cid = '0; m_cval = '0; m_rid = '0; m_rflags = '0; m_rwbs = '0; m_rval = '0;
    end else if (flush) begin
      m_cgnt = '0; m_rgnt = '0;
    end else begin
      w = pick(cdb_req & ~m_cgnt, m_cptr);
      if (w >= 0) begin
        m_cgnt = 4'(1 << w);
        m_cid  = cdb_req_id[w*4 +: 4];
        m_cval = cdb_req_val[w*8 +: 8];
        m_cptr = (w + 1) % NF;
      end else m_cgnt = '0;
      w = pick(rob_req & ~m_rgnt, m_rptr);
      if (w >= 0) begin
        m_rgnt   = 4'(1 << w);
        m_rid    = rob_req_id[w*4 +: 4];
        m_rflags = rob_req_flags[w*8 +: 8];
        m_rwbs   = rob_req_wbs[w*8 +: 8];
        m_rval   = rob_req_value[w*8 +: 8];
        m_rptr   = (w + 1) % NF;
      end else m_rgnt = '0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle against the model
  always @(negedge clk) begin
    check("m_cdb_gnt", 32'(cdb_gnt), 32'(m_cgnt));
    check("m_cdb_valid", 32'(cdb_valid), 32'(m_cgnt != 0));
    check("m_rob_gnt", 32'(rob_gnt), 32'(m_rgnt));
    check("m_rob_valid", 32'(rob_valid), 32'(m_rgnt != 0));
    if (m_cgnt != 0 || !rst) begin
      check("m_cdb_id", 32'(cdb_id), 32'(m_cid));
      check("m_cdb_val", 32'(cdb_val), 32'(m_cval));
    end
    if (m_rgnt != 0 || !rst) begin
      check("m_rob_id", 32'(rob_id), 32'(m_rid));
      check("m_rob_flags", 32'(rob_flags), 32'(m_rflags));
      check("m_rob_wbs", 32'(rob_wbs), 32'(m_rwbs));
      check("m_rob_value", 32'(rob_value), 32'(m_rval));
    end
  end

  // Advance to just after the next falling edge (outputs stable, inputs safe)
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // 1. reset with everyone requesting, then release
    #2 rst = 1'b0;
    cdb_req = 4'b1111; rob_req = 4'b1111;
    tick(); tick();
    check("rst_cdb_gnt", 32'(cdb_gnt), 32'h0);
    check("rst_rob_valid", 32'(rob_valid), 32'h0);
    rst = 1'b1;
    tick();
    check("first_cdb_gnt", 32'(cdb_gnt), 32'b0001);
    check("first_rob_gnt", 32'(rob_gnt), 32'b0001);
    check("first_cdb_val", 32'(cdb_val), 32'h28);
    cdb_req = '0; rob_req = '0;
    tick();
    check("idle_cdb_valid", 32'(cdb_valid), 32'h0);

    // 2. single requester FU2 (cdb ptr 1 -> 3)
    cdb_req = 4'b0100;
    tick();
    check("single_gnt", 32'(cdb_gnt), 32'b0100);
    check("single_id", 32'(cdb_id), 32'h3);
    check("single_val", 32'(cdb_val), 32'h2A);
    cdb_req = '0;
    tick();
    check("single_after", 32'(cdb_gnt), 32'h0);

    // 4. ptr=3, req=1001 -> FU3 then FU0
    cdb_req = 4'b1001;
    tick();
    check("wrap_gnt3", 32'(cdb_gnt), 32'b1000);
    cdb_req = 4'b0001;
    tick();
    check("wrap_gnt0", 32'(cdb_gnt), 32'b0001);
    // park pointer at 0 via a lone FU3 grant
    cdb_req = 4'b1000;
    tick();
    check("park_gnt3", 32'(cdb_gnt), 32'b1000);

    // 3. all FUs requesting, each drops for one cycle after its grant
    for (int k = 0; k < 8; k++) begin
      cdb_req = 4'b1111 & ~cdb_gnt;
      tick();
      check("rr_order", 32'(cdb_gnt), 32'(1 << (k % 4)));
    end
    cdb_req = '0;
    tick();

    // 5. independent buses: CDB FU0, ROB FU1
    cdb_req = 4'b0001; rob_req = 4'b0010;
    tick();
    check("dual_cdb_gnt", 32'(cdb_gnt), 32'b0001);
    check("dual_rob_gnt", 32'(rob_gnt), 32'b0010);
    check("dual_rob_value", 32'(rob_value), 32'h51);
    check("dual_rob_flags", 32'(rob_flags), 32'h02);
    cdb_req = '0; rob_req = '0;
    tick();

    // 6. flush beats requests, pointers retained (cdb ptr 1, rob ptr 2)
    flush = 1'b1; cdb_req = 4'b1111; rob_req = 4'b1111;
    tick();
    check("flush_cdb_valid", 32'(cdb_valid), 32'h0);
    check("flush_rob_gnt", 32'(rob_gnt), 32'h0);
    flush = 1'b0;
    tick();
    check("resume_cdb_gnt", 32'(cdb_gnt), 32'b0010);
    check("resume_rob_gnt", 32'(rob_gnt), 32'b0100);
    cdb_req = '0; rob_req = '0;
    tick();

    // reset in the middle of a grant drops outputs immediately
    cdb_req = 4'b1000; rob_req = 4'b1000;
    tick();
    check("pre_rst_valid", 32'(cdb_valid), 32'h1);
    rst = 1'b0;
    #1;
    check("async_cdb_gnt", 32'(cdb_gnt), 32'h0);
    check("async_rob_value", 32'(rob_value), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_gnt", 32'(cdb_gnt), 32'b1000);
    cdb_req = '0; rob_req = '0;
    tick();

    // mixed held requests, model-checked
    cdb_req = 4'b0110; rob_req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      tick();
      cdb_req = 4'b0110 & ~cdb_gnt;
      rob_req = 4'b1010 & ~rob_gnt;
    end
    cdb_req = '0; rob_req = '0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
